pbit_histogram: RTL and testbench
=================================

PBIT_HISTOGRAM -- requirements
Module: pbit_histogram

Interface
REQ-001 Parameter SAMPLE_DIV, default 6, SHALL set the number of CLK cycles between samples (legal range 1..255).
REQ-002 Parameter NUM_SAMPLES, default 1000, SHALL set the samples per run (legal range 1..65535).
REQ-003 Parameter CNT_W, default 16, SHALL set the width of each bin counter.
REQ-004 CLK  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 RST  input  1  SHALL be the synchronous, active-high reset.
REQ-006 m1, m2, m3  input  1 each  SHALL carry the p-bit network outputs; bin index = {m1,m2,m3} (m1 is the MSB).
REQ-007 start  input  1  SHALL be a single-cycle pulse that requests a new run.
REQ-008 busy  output  1  SHALL be high while a run is in progress.
REQ-009 done  output  1  SHALL be high from run completion until the next accepted start or RST.
REQ-010 rd_en  input  1  SHALL request a bin read.
REQ-011 rd_addr  input  3  SHALL select the bin to read.
REQ-012 rd_data  output  CNT_W  SHALL carry the registered bin count.
REQ-013 rd_valid  output  1  SHALL qualify rd_data for one cycle.

Function
REQ-014 The block SHALL implement the states IDLE, SAMPLE and DONE.
REQ-015 In IDLE or DONE, start=1 SHALL, on that edge, clear all 8 bins, the sample counter and the divider, and enter SAMPLE.
- busy=1 and done=0 from the next cycle.
REQ-016 In SAMPLE, start SHALL be ignored.
REQ-017 In SAMPLE, the divider SHALL count 0..SAMPLE_DIV-1, incrementing once per cycle.
- On the cycle where divider==SAMPLE_DIV-1, the block SHALL sample {m1,m2,m3}, increment that bin, increment the sample counter, and reset the divider to 0.
REQ-018 The first sample SHALL occur on the SAMPLE_DIV-th cycle in SAMPLE.
- Run length SHALL be exactly NUM_SAMPLES*SAMPLE_DIV cycles.
REQ-019 When the NUM_SAMPLES-th sample is taken, the block SHALL enter DONE on the same edge.
- busy=0 and done=1 from the next cycle; bins SHALL then hold.
REQ-020 Bin increments SHALL saturate at 2^CNT_W-1; there SHALL be no wrap-around.
REQ-021 Only one bin SHALL change per sample.
- Absent saturation, the sum of all bins at DONE SHALL equal NUM_SAMPLES.
REQ-022 rd_en=1 in any state SHALL produce rd_valid=1 on the next cycle, with rd_data = bin[rd_addr] as of the rd_en edge.
- Back-to-back reads SHALL be supported at one per cycle.
REQ-023 rd_en=0 SHALL give rd_valid=0 on the next cycle; rd_data SHALL then hold its last value.
REQ-024 A read of the bin being incremented on the same edge SHALL return the pre-increment value.
REQ-025 Inputs m1..m3 SHALL be treated as synchronous to CLK; no synchronizers.

Reset
REQ-026 RST=1 SHALL take precedence over start, rd_en and sampling on the same edge.
REQ-027 RST=1 SHALL force the following state on the next edge:
- state=IDLE, busy=0, done=0, rd_valid=0, rd_data=0
- all bins=0, divider=0, sample counter=0
REQ-028 RST asserted mid-run SHALL abort the run and discard all counts.
REQ-029 After RST deasserts, the block SHALL stay in IDLE until start.

Verification
REQ-030 Constant capture: SAMPLE_DIV=6, NUM_SAMPLES=10, {m1,m2,m3}=3'b101, start pulse -> busy high 60 cycles; done then high; reads give bin5=10, all other bins=0.
REQ-031 Alternating input: SAMPLE_DIV=1, NUM_SAMPLES=8, input toggles 3'b000/3'b111 every cycle -> bin0=4, bin7=4, all others 0.
REQ-032 Saturation: CNT_W=4, NUM_SAMPLES=20, constant 3'b011 -> bin3=15.
REQ-033 Run-control edge cases:
- start pulsed mid-run -> run length unchanged.
- RST at cycle 25 of a 60-cycle run -> all bins read 0, busy=0, done=0.
REQ-034 Read timing and restart:
- rd_en on consecutive cycles for addrs 0..7 -> rd_valid high 8 cycles, data in address order, 1-cycle latency.
- start in DONE -> bins cleared, new run begins.

Source files
------------

// File: rtl/pbit_histogram_if.sv
// Bus bundle for the p-bit histogram: p-bit inputs, run control and the
// bin read port. The master drives stimulus/reads; the slave is the block.
interface pbit_histogram_if #(
    parameter int CNT_W = 16
);
    logic             m1;
    logic             m2;
    logic             m3;
    logic             start;
    logic             busy;
    logic             done;
    logic             rd_en;
    logic [2:0]       rd_addr;
    logic [CNT_W-1:0] rd_data;
    logic             rd_valid;

    modport master (
        output m1, m2, m3, start, rd_en, rd_addr,
        input  busy, done, rd_data, rd_valid
    );

    modport slave (
        input  m1, m2, m3, start, rd_en, rd_addr,
        output busy, done, rd_data, rd_valid
    );
endinterface

// File: rtl/pbit_histogram.sv
// Eight-bin histogram of a 3-bit p-bit network state. A run takes
// NUM_SAMPLES samples, one every SAMPLE_DIV clocks, into saturating bin
// counters that can be read back at any time through a registered port.
module pbit_histogram #(
    parameter int SAMPLE_DIV  = 6,
    parameter int NUM_SAMPLES = 1000,
    parameter int CNT_W       = 16
) (
    input  logic            CLK,
    input  logic            RST,
    pbit_histogram_if.slave bus
);
    localparam int NUM_BINS = 8;
    localparam int DIV_W    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int SMP_W    = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(NUM_SAMPLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SAMPLE = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [SMP_W-1:0] smp_q, smp_d;
    logic [CNT_W-1:0] bin_q [NUM_BINS];
    logic [CNT_W-1:0] bin_d [NUM_BINS];
    logic             rd_valid_q, rd_valid_d;
    logic [CNT_W-1:0] rd_data_q, rd_data_d;

    logic [2:0]       sample_idx;
    logic             start_accept;
    logic             sample_tick;
    logic             last_sample;

    // Run-control decode shared by the FSM and the datapath.
    always_comb begin
        sample_idx   = {bus.m1, bus.m2, bus.m3};
        start_accept = bus.start && (state_q == ST_IDLE || state_q == ST_DONE);
        sample_tick  = (state_q == ST_SAMPLE) && (div_q == DIV_LAST);
        last_sample  = sample_tick && (smp_q == SMP_LAST);
    end

    // FSM state register.
    always_ff @(posedge CLK) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of process ordering.
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: start is only honoured outside SAMPLE; the last sample
    // moves to DONE on the same edge it is taken.
    always_comb begin
        // NOTE: the default assignment up front keeps every path assigned,
        // so no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (start_accept) state_d = ST_SAMPLE;
            ST_SAMPLE: if (last_sample)  state_d = ST_DONE;
            ST_DONE:   if (start_accept) state_d = ST_SAMPLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // FSM outputs, decoded from the state register so they change one cycle
    // after the deciding edge.
    always_comb begin
        bus.busy = (state_q == ST_SAMPLE);
        bus.done = (state_q == ST_DONE);
    end

    // Sample divider and sample counter next state.
    always_comb begin
        div_d = div_q;
        smp_d = smp_q;
        if (start_accept) begin
            div_d = '0;
            smp_d = '0;
        end else if (state_q == ST_SAMPLE) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
            // Hold at the final count so the counter never wraps in DONE.
            if (sample_tick && !last_sample) begin
                smp_d = smp_q + SMP_W'(1);
            end
        end
    end

    // Divider and sample counter registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            div_q <= '0;
            smp_q <= '0;
        end else begin
            div_q <= div_d;
            smp_q <= smp_d;
        end
    end

    // Bin next state: cleared on an accepted start, otherwise the sampled bin
    // steps by one and sticks at full scale.
    always_comb begin
        for (int i = 0; i < NUM_BINS; i++) begin
            bin_d[i] = start_accept ? '0 : bin_q[i];
        end
        if (sample_tick && (bin_q[sample_idx] != CNT_MAX)) begin
            bin_d[sample_idx] = bin_q[sample_idx] + CNT_W'(1);
        end
    end

    // Bin registers.
    always_ff @(posedge CLK) begin
        // NOTE: the bins are a small register file, not RAM, and a reset must
        // discard an aborted run, so every entry is explicitly reset.
        if (RST) begin
            for (int i = 0; i < NUM_BINS; i++) begin
                bin_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_BINS; i++) begin
                bin_q[i] <= bin_d[i];
            end
        end
    end

    // Read port next state: data captured from the pre-increment bins, held
    // between reads.
    always_comb begin
        rd_valid_d = bus.rd_en;
        rd_data_d  = bus.rd_en ? bin_q[bus.rd_addr] : rd_data_q;
    end

    // Read port registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // Read port outputs.
    always_comb begin
        bus.rd_valid = rd_valid_q;
        bus.rd_data  = rd_data_q;
    end
endmodule

// File: tb/tb_pbit_histogram.sv
// Bench for pbit_histogram: three instances cover the constant-capture,
// alternating-input and saturation configurations. Reads are scoreboarded:
// each issued read pushes its expected count, and a per-instance monitor pops
// and compares when rd_valid appears, checking rd_data holds otherwise.
module tb_pbit_histogram;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    logic rst_c = 1'b1;

    int checks = 0;
    int errors = 0;

    pbit_histogram_if #(.CNT_W(16)) bus_a ();
    pbit_histogram_if #(.CNT_W(16)) bus_b ();
    pbit_histogram_if #(.CNT_W(4))  bus_c ();

    pbit_histogram #(.SAMPLE_DIV(6), .NUM_SAMPLES(10), .CNT_W(16)) u_a (
        .CLK(clk), .RST(rst_a), .bus(bus_a)
    );
    pbit_histogram #(.SAMPLE_DIV(1), .NUM_SAMPLES(8), .CNT_W(16)) u_b (
        .CLK(clk), .RST(rst_b), .bus(bus_b)
    );
    pbit_histogram #(.SAMPLE_DIV(2), .NUM_SAMPLES(20), .CNT_W(4)) u_c (
        .CLK(clk), .RST(rst_c), .bus(bus_c)
    );

    logic [15:0] q_a[$];
    logic [15:0] q_b[$];
    logic [15:0] q_c[$];
    int          model_a[8];
    int          model_b[8];
    int          model_c[8];

    // Reset as seen by the last rising edge, so monitors know rd_data is 0.
    logic rst_edge_a = 1'b1;
    logic rst_edge_b = 1'b1;
    logic rst_edge_c = 1'b1;
    always @(posedge clk) begin
        rst_edge_a <= rst_a;
        rst_edge_b <= rst_b;
        rst_edge_c <= rst_c;
    end

    logic [15:0] last_a = '0;
    logic [15:0] last_b = '0;
    logic [15:0] last_c = '0;

    always @(negedge clk) begin
        logic [15:0] e;
        if (rst_edge_a) begin
            q_a.delete();
            last_a = '0;
        end else if (bus_a.rd_valid) begin
            checks++;
            if (q_a.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected_a got data=%0d with no read pending", bus_a.rd_data);
            end else begin
                e = q_a.pop_front();
                last_a = e;
                if (bus_a.rd_data !== e) begin
                    errors++;
                    $display("FAIL rd_data_a got %0d expected %0d", bus_a.rd_data, e);
                end
            end
        end else begin
            checks++;
            if (bus_a.rd_data !== last_a) begin
                errors++;
                $display("FAIL rd_hold_a got %0d expected %0d", bus_a.rd_data, last_a);
            end
        end
    end

    always @(negedge clk) begin
        logic [15:0] e;
        if (rst_edge_b) begin
            q_b.delete();
            last_b = '0;
        end else if (bus_b.rd_valid) begin
            checks++;
            if (q_b.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected_b got data=%0d with no read pending", bus_b.rd_data);
            end else begin
                e = q_b.pop_front();
                last_b = e;
                if (bus_b.rd_data !== e) begin
                    errors++;
                    $display("FAIL rd_data_b got %0d expected %0d", bus_b.rd_data, e);
                end
            end
        end else begin
            checks++;
            if (bus_b.rd_data !== last_b) begin
                errors++;
                $display("FAIL rd_hold_b got %0d expected %0d", bus_b.rd_data, last_b);
            end
        end
    end

    always @(negedge clk) begin
        logic [15:0] e;
        if (rst_edge_c) begin
            q_c.delete();
            last_c = '0;
        end else if (bus_c.rd_valid) begin
            checks++;
            if (q_c.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected_c got data=%0d with no read pending", bus_c.rd_data);
            end else begin
                e = q_c.pop_front();
                last_c = e;
                if ({12'b0, bus_c.rd_data} !== e) begin
                    errors++;
                    $display("FAIL rd_data_c got %0d expected %0d", bus_c.rd_data, e);
                end
            end
        end else begin
            checks++;
            if ({12'b0, bus_c.rd_data} !== last_c) begin
                errors++;
                $display("FAIL rd_hold_c got %0d expected %0d", bus_c.rd_data, last_c);
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic issue_a(input logic [2:0] a, input logic [15:0] e);
        bus_a.rd_en = 1'b1; bus_a.rd_addr = a; q_a.push_back(e);
    endtask

    task automatic issue_b(input logic [2:0] a, input logic [15:0] e);
        bus_b.rd_en = 1'b1; bus_b.rd_addr = a; q_b.push_back(e);
    endtask

    task automatic issue_c(input logic [2:0] a, input logic [15:0] e);
        bus_c.rd_en = 1'b1; bus_c.rd_addr = a; q_c.push_back(e);
    endtask

    // Wait (bounded) until every issued read has been answered.
    task automatic drain();
        for (int i = 0; i < 20; i++) begin
            if (q_a.size() == 0 && q_b.size() == 0 && q_c.size() == 0) break;
            step();
        end
        checks++;
        if (q_a.size() + q_b.size() + q_c.size() != 0) begin
            errors++;
            $display("FAIL drain pending reads=%0d expected 0", q_a.size() + q_b.size() + q_c.size());
        end
    endtask

    task automatic read_all_a();
        for (int a = 0; a < 8; a++) begin step(); issue_a(3'(a), 16'(model_a[a])); end
        step(); bus_a.rd_en = 1'b0;
        drain();
    endtask

    task automatic read_all_b();
        for (int a = 0; a < 8; a++) begin step(); issue_b(3'(a), 16'(model_b[a])); end
        step(); bus_b.rd_en = 1'b0;
        drain();
    endtask

    task automatic read_all_c();
        for (int a = 0; a < 8; a++) begin step(); issue_c(3'(a), 16'(model_c[a])); end
        step(); bus_c.rd_en = 1'b0;
        drain();
    endtask

    task automatic check_run_end(input string name, input int busy_cnt, input int want,
                                 input logic busy, input logic done);
        checks++;
        if (busy_cnt != want) begin
            errors++;
            $display("FAIL %s_busy_cycles got %0d expected %0d", name, busy_cnt, want);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL %s_done_flags got busy=%b done=%b expected busy=0 done=1", name, busy, done);
        end
    endtask

    // Reset dominates start and rd_en asserted on the same edge.
    task automatic test_reset();
        repeat (2) step();
        bus_a.start = 1'b1; bus_a.rd_en = 1'b1; bus_a.rd_addr = 3'd5;
        bus_b.start = 1'b1; bus_c.start = 1'b1;
        step();
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        bus_a.start = 1'b0; bus_a.rd_en = 1'b0;
        bus_b.start = 1'b0; bus_c.start = 1'b0;
        step();
        checks++;
        if ({bus_a.busy, bus_a.done, bus_a.rd_valid} !== 3'b000 || bus_a.rd_data !== 16'd0) begin
            errors++;
            $display("FAIL reset_a got busy/done/valid=%b data=%0d expected 000 and 0",
                     {bus_a.busy, bus_a.done, bus_a.rd_valid}, bus_a.rd_data);
        end
        checks++;
        if ({bus_b.busy, bus_b.done, bus_b.rd_valid} !== 3'b000 || bus_b.rd_data !== 16'd0) begin
            errors++;
            $display("FAIL reset_b got busy/done/valid=%b data=%0d expected 000 and 0",
                     {bus_b.busy, bus_b.done, bus_b.rd_valid}, bus_b.rd_data);
        end
        checks++;
        if ({bus_c.busy, bus_c.done, bus_c.rd_valid} !== 3'b000 || bus_c.rd_data !== 4'd0) begin
            errors++;
            $display("FAIL reset_c got busy/done/valid=%b data=%0d expected 000 and 0",
                     {bus_c.busy, bus_c.done, bus_c.rd_valid}, bus_c.rd_data);
        end
        for (int k = 0; k < 8; k++) begin model_a[k] = 0; model_b[k] = 0; model_c[k] = 0; end
        read_all_a();
    endtask

    // Constant 3'b101 for 10 samples at divide-by-6; includes reads that hit
    // the first sampling edge (pre-increment) and the one after it.
    task automatic test_constant_capture();
        int busy_cnt = 0;
        step();
        {bus_a.m1, bus_a.m2, bus_a.m3} = 3'b101;
        bus_a.start = 1'b1;
        for (int i = 1; i <= 200; i++) begin
            step();
            bus_a.start = 1'b0;
            bus_a.rd_en = 1'b0;
            if (i == 6) issue_a(3'd5, 16'd0);
            if (i == 7) issue_a(3'd5, 16'd1);
            if (!bus_a.busy) break;
            busy_cnt++;
        end
        check_run_end("const", busy_cnt, 60, bus_a.busy, bus_a.done);
        for (int k = 0; k < 8; k++) model_a[k] = (k == 5) ? 10 : 0;
        read_all_a();
        checks++;
        if (bus_a.done !== 1'b1) begin
            errors++;
            $display("FAIL const_done_holds got %b expected 1", bus_a.done);
        end
    endtask

    // Input toggles 000/111 every cycle with one sample per cycle.
    task automatic test_alternating();
        int busy_cnt = 0;
        logic [2:0] v;
        for (int k = 0; k < 8; k++) model_b[k] = 0;
        step();
        {bus_b.m1, bus_b.m2, bus_b.m3} = 3'b000;
        bus_b.start = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            step();
            bus_b.start = 1'b0;
            v = (i % 2 == 1) ? 3'b111 : 3'b000;
            {bus_b.m1, bus_b.m2, bus_b.m3} = v;
            if (i <= 8) model_b[v]++;
            if (!bus_b.busy) break;
            busy_cnt++;
        end
        check_run_end("alt", busy_cnt, 8, bus_b.busy, bus_b.done);
        read_all_b();
    endtask

    // 20 samples of 3'b011 into 4-bit bins must stop at 15.
    task automatic test_saturation();
        int busy_cnt = 0;
        for (int k = 0; k < 8; k++) model_c[k] = 0;
        step();
        {bus_c.m1, bus_c.m2, bus_c.m3} = 3'b011;
        bus_c.start = 1'b1;
        for (int i = 1; i <= 200; i++) begin
            step();
            bus_c.start = 1'b0;
            if (i <= 40 && i % 2 == 0 && model_c[3] < 15) model_c[3]++;
            if (!bus_c.busy) break;
            busy_cnt++;
        end
        check_run_end("sat", busy_cnt, 40, bus_c.busy, bus_c.done);
        read_all_c();
    endtask

    // Restart from DONE clears the bins; a start pulse mid-run is ignored.
    task automatic test_restart_mid_start();
        int busy_cnt = 0;
        logic [2:0] v;
        for (int k = 0; k < 8; k++) model_a[k] = 0;
        step();
        bus_a.start = 1'b1;
        for (int i = 1; i <= 200; i++) begin
            step();
            bus_a.start = (i == 20);
            bus_a.rd_en = 1'b0;
            v = 3'($urandom_range(0, 7));
            {bus_a.m1, bus_a.m2, bus_a.m3} = v;
            if (i <= 60 && i % 6 == 0) model_a[v]++;
            if (i == 1) begin
                checks++;
                if (bus_a.busy !== 1'b1 || bus_a.done !== 1'b0) begin
                    errors++;
                    $display("FAIL restart_flags got busy=%b done=%b expected busy=1 done=0",
                             bus_a.busy, bus_a.done);
                end
                issue_a(3'd5, 16'd0);
            end
            if (!bus_a.busy) break;
            busy_cnt++;
        end
        bus_a.start = 1'b0;
        check_run_end("mid_start", busy_cnt, 60, bus_a.busy, bus_a.done);
    endtask

    // Reads 0..7 on consecutive cycles: eight valid cycles, address order.
    task automatic test_back_to_back();
        int vcnt = 0;
        for (int i = 0; i <= 8; i++) begin
            step();
            if (bus_a.rd_valid) vcnt++;
            if (i < 8) issue_a(3'(i), 16'(model_a[i]));
            else bus_a.rd_en = 1'b0;
        end
        step();
        checks++;
        if (vcnt != 8 || bus_a.rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_valid got %0d valid cycles then valid=%b expected 8 then 0",
                     vcnt, bus_a.rd_valid);
        end
        drain();
    endtask

    // Reset at cycle 25 of a run: counts discarded, block stays idle.
    task automatic test_reset_mid_run();
        int busy_seen = 0;
        step();
        {bus_a.m1, bus_a.m2, bus_a.m3} = 3'b110;
        bus_a.start = 1'b1;
        for (int i = 1; i <= 120; i++) begin
            step();
            bus_a.start = 1'b0;
            rst_a = (i == 25);
            if (i == 24) begin
                checks++;
                if (bus_a.busy !== 1'b1) begin
                    errors++;
                    $display("FAIL rst_mid_prebusy got %b expected 1", bus_a.busy);
                end
            end
            if (i >= 27 && (bus_a.busy !== 1'b0 || bus_a.done !== 1'b0)) busy_seen++;
        end
        checks++;
        if (busy_seen != 0 || bus_a.busy !== 1'b0 || bus_a.done !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_idle got %0d non-idle cycles, busy=%b done=%b expected 0,0,0",
                     busy_seen, bus_a.busy, bus_a.done);
        end
        for (int k = 0; k < 8; k++) model_a[k] = 0;
        read_all_a();
    endtask

    initial begin
        bus_a.m1 = 1'b0; bus_a.m2 = 1'b0; bus_a.m3 = 1'b0;
        bus_a.start = 1'b0; bus_a.rd_en = 1'b0; bus_a.rd_addr = 3'd0;
        bus_b.m1 = 1'b0; bus_b.m2 = 1'b0; bus_b.m3 = 1'b0;
        bus_b.start = 1'b0; bus_b.rd_en = 1'b0; bus_b.rd_addr = 3'd0;
        bus_c.m1 = 1'b0; bus_c.m2 = 1'b0; bus_c.m3 = 1'b0;
        bus_c.start = 1'b0; bus_c.rd_en = 1'b0; bus_c.rd_addr = 3'd0;

        test_reset();
        test_constant_capture();
        test_alternating();
        test_saturation();
        test_restart_mid_start();
        test_back_to_back();
        test_reset_mid_run();

        repeat (3) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
